// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: takes PC/PC+4 from the PC register and fetches over req/gnt/rvalid,
// then hands {pc, pc4, instr} to decode through a DEPTH-entry FIFO. Optional macro: IFETCH_BYPASS_EN.
module ifetch_queue #(
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     pc_i,
    input  logic [31:0]     pc4_i,
    input  logic            pc_valid_i,
    output logic            pc_ready_o,
    output logic            imem_req_o,
    output logic [31:0]     imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            flush_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [31:0]     id_pc_o,
    output logic [31:0]     id_pc4_o,
    output logic [31:0]     id_instr_o,
    output logic [CNTW-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     pc4_q, pc4_d;
    logic [31:0]     addr_q, addr_d;
    logic            kill_q, kill_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic [31:0]     fifo_pc_q    [DEPTH];
    logic [31:0]     fifo_pc4_q   [DEPTH];
    logic [31:0]     fifo_instr_q [DEPTH];

    logic accept, resp, push, pop, fifo_empty, fifo_full;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNTW'(DEPTH));
    // Slot is reserved at accept time; only one fetch is ever in flight, so a push cannot overflow.
    assign accept     = (state_q == IDLE) & pc_valid_i & ~flush_i & ~fifo_full & ~rst;
    assign resp       = (state_q == WAIT) & imem_rvalid_i;
    assign pop        = ~fifo_empty & id_ready_i & ~flush_i;

`ifdef IFETCH_BYPASS_EN
    logic bypass;
    // An empty queue lets a live response go straight to decode; it is stored only if not taken.
    assign bypass     = resp & ~kill_q & ~flush_i & fifo_empty;
    assign push       = resp & ~kill_q & ~flush_i & ~(bypass & id_ready_i);
    assign id_valid_o = ~fifo_empty | bypass;
    assign id_pc_o    = bypass ? pc_q         : fifo_pc_q[rd_ptr_q];
    assign id_pc4_o   = bypass ? pc4_q        : fifo_pc4_q[rd_ptr_q];
    assign id_instr_o = bypass ? imem_rdata_i : fifo_instr_q[rd_ptr_q];
`else
    assign push       = resp & ~kill_q & ~flush_i;
    assign id_valid_o = ~fifo_empty;
    assign id_pc_o    = fifo_pc_q[rd_ptr_q];
    assign id_pc4_o   = fifo_pc4_q[rd_ptr_q];
    assign id_instr_o = fifo_instr_q[rd_ptr_q];
`endif

    assign pc_ready_o  = accept;
    assign imem_req_o  = (state_q == REQ);
    assign imem_addr_o = addr_q;
    assign count_o     = count_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        addr_d  = addr_q;
        kill_d  = kill_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pc_d    = pc_i;
                    pc4_d   = pc4_i;
                    addr_d  = {pc_i[31:2], 2'b00};
                    state_d = REQ;
                end
            end
            REQ: begin
                if (flush_i) kill_d = 1'b1;
                if (imem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                // A response in the flush cycle is dropped here, so kill must not outlive it.
                if (resp) begin
                    kill_d  = 1'b0;
                    state_d = IDLE;
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            pc4_q   <= '0;
            addr_q  <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            addr_q  <= addr_d;
            kill_q  <= kill_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push & ~pop)      count_q <= count_q + 1'b1;
            else if (pop & ~push) count_q <= count_q - 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    fifo_pc_q[gi]    <= '0;
                    fifo_pc4_q[gi]   <= '0;
                    fifo_instr_q[gi] <= '0;
                end else if (push && wr_ptr_q == AW'(gi)) begin
                    fifo_pc_q[gi]    <= pc_q;
                    fifo_pc4_q[gi]   <= pc4_q;
                    fifo_instr_q[gi] <= imem_rdata_i;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: table-driven fill plus hand-written flush/reset/backpressure
// sequences, with a scoreboard queue of expected decode entries.
module tb_ifetch_queue;
    localparam int DEPTH = 4;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     pc_i, pc4_i;
    logic            pc_valid_i;
    logic            pc_ready_o;
    logic            imem_req_o;
    logic [31:0]     imem_addr_o;
    logic            imem_gnt_i, imem_rvalid_i;
    logic [31:0]     imem_rdata_i;
    logic            flush_i;
    logic            id_valid_o, id_ready_i;
    logic [31:0]     id_pc_o, id_pc4_o, id_instr_o;
    logic [CNTW-1:0] count_o;

    ifetch_queue #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .pc_i(pc_i), .pc4_i(pc4_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .flush_i(flush_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_pc_o(id_pc_o),
        .id_pc4_o(id_pc4_o), .id_instr_o(id_instr_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          gnt_dly;
        int          exp_cnt;
    } vec_t;

    ent_t sb[$];
    vec_t vecs[4];
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Consume the head for one cycle and compare it with the oldest expected entry.
    task automatic pop_check();
        ent_t e;
        if (sb.size() == 0) begin
            chk("pop_sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        id_ready_i = 1'b1;
        #1;
        chk("pop_valid", {31'd0, id_valid_o}, 32'd1);
        chk("pop_pc", id_pc_o, e.pc);
        chk("pop_pc4", id_pc4_o, e.pc4);
        chk("pop_instr", id_instr_o, e.instr);
        $display("pop pc=%h pc4=%h instr=%h", id_pc_o, id_pc4_o, id_instr_o);
        tick();
        id_ready_i = 1'b0;
        chk("pop_count", {{(32-CNTW){1'b0}}, count_o}, sb.size());
    endtask

    // One full fetch; optionally consume the head in the same cycle the response arrives.
    task automatic fetch_one(input logic [31:0] pc, input logic [31:0] instr,
                             input int dly, input bit pop_on_rsp);
        ent_t e;
        pc_valid_i = 1'b1;
        pc_i       = pc;
        pc4_i      = pc + 32'd4;
        #1;
        chk("f_ready", {31'd0, pc_ready_o}, 32'd1);
        sb.push_back('{pc: pc, pc4: pc + 32'd4, instr: instr});
        tick();
        chk("f_req", {31'd0, imem_req_o}, 32'd1);
        chk("f_addr", imem_addr_o, {pc[31:2], 2'b00});
        chk("f_noaccept", {31'd0, pc_ready_o}, 32'd0);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("f_req_hold", {31'd0, imem_req_o}, 32'd1);
            chk("f_addr_hold", imem_addr_o, {pc[31:2], 2'b00});
            chk("f_noaccept_hold", {31'd0, pc_ready_o}, 32'd0);
        end
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        pc_valid_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = instr;
        if (pop_on_rsp) begin
            e = sb.pop_front();
            id_ready_i = 1'b1;
            #1;
            chk("f_pp_pc", id_pc_o, e.pc);
            chk("f_pp_instr", id_instr_o, e.instr);
            $display("pop pc=%h instr=%h (with push)", id_pc_o, id_instr_o);
        end
        tick();
        imem_rvalid_i = 1'b0;
        id_ready_i    = 1'b0;
        $display("fetch pc=%h instr=%h count=%0d", pc, instr, count_o);
        chk("f_count", {{(32-CNTW){1'b0}}, count_o}, sb.size());
    endtask

    // Back-to-back fastest fetch of PC 0 with latency checks.
    task automatic first_fetch();
        pc_valid_i = 1'b1;
        pc_i       = 32'h0;
        pc4_i      = 32'h4;
        #1;
        chk("s1_ready", {31'd0, pc_ready_o}, 32'd1);
        sb.push_back('{pc: 32'h0, pc4: 32'h4, instr: 32'h00500093});
        tick();
        pc_valid_i = 1'b0;
        chk("s1_req", {31'd0, imem_req_o}, 32'd1);
        chk("s1_addr", imem_addr_o, 32'h0);
        chk("s1_nvalid_t1", {31'd0, id_valid_o}, 32'd0);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h00500093;
        #1;
`ifdef IFETCH_BYPASS_EN
        chk("s1_byp_valid", {31'd0, id_valid_o}, 32'd1);
        chk("s1_byp_instr", id_instr_o, 32'h00500093);
`else
        chk("s1_nvalid_t2", {31'd0, id_valid_o}, 32'd0);
`endif
        tick();
        imem_rvalid_i = 1'b0;
        chk("s1_valid", {31'd0, id_valid_o}, 32'd1);
        chk("s1_pc", id_pc_o, 32'h0);
        chk("s1_pc4", id_pc4_o, 32'h4);
        chk("s1_instr", id_instr_o, 32'h00500093);
        chk("s1_count", {{(32-CNTW){1'b0}}, count_o}, 32'd1);
        pop_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{pc: 32'h0, instr: 32'h11111111, gnt_dly: 0, exp_cnt: 1};
        vecs[1] = '{pc: 32'h4, instr: 32'h22222222, gnt_dly: 0, exp_cnt: 2};
        vecs[2] = '{pc: 32'h8, instr: 32'h33333333, gnt_dly: 3, exp_cnt: 3};
        vecs[3] = '{pc: 32'hC, instr: 32'h44444444, gnt_dly: 1, exp_cnt: 4};

        rst = 1'b1;
        pc_i = '0; pc4_i = '0; pc_valid_i = 1'b1;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        flush_i = 1'b0; id_ready_i = 1'b0;
        #2;
        chk("rst_ready", {31'd0, pc_ready_o}, 32'd0);
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_addr", imem_addr_o, 32'd0);
        chk("rst_valid", {31'd0, id_valid_o}, 32'd0);
        chk("rst_count", {{(32-CNTW){1'b0}}, count_o}, 32'd0);
        chk("rst_idpc", id_pc_o, 32'd0);
        chk("rst_instr", id_instr_o, 32'd0);
        pc_valid_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        first_fetch();

        // Fill the queue; the third entry sees a 3-cycle grant delay.
        for (int i = 0; i < 4; i++) begin
            fetch_one(vecs[i].pc, vecs[i].instr, vecs[i].gnt_dly, 1'b0);
            chk("tbl_count", {{(32-CNTW){1'b0}}, count_o}, vecs[i].exp_cnt);
        end
        chk("full_head", id_pc_o, 32'h0);
        pc_valid_i = 1'b1;
        pc_i       = 32'h10;
        pc4_i      = 32'h14;
        #1;
        chk("full_noready", {31'd0, pc_ready_o}, 32'd0);
        tick();
        pc_valid_i = 1'b0;
        chk("full_noreq", {31'd0, imem_req_o}, 32'd0);
        chk("full_count", {{(32-CNTW){1'b0}}, count_o}, 32'd4);
        pop_check();
        fetch_one(32'h10, 32'h55555555, 0, 1'b0);
        chk("refill_count", {{(32-CNTW){1'b0}}, count_o}, 32'd4);
        pop_check();
        fetch_one(32'h14, 32'h66666666, 0, 1'b1);
        chk("pushpop_count", {{(32-CNTW){1'b0}}, count_o}, 32'd3);
        while (sb.size() > 0) pop_check();
        chk("drained_valid", {31'd0, id_valid_o}, 32'd0);

        // Flush with two entries queued and a fetch waiting for its response.
        fetch_one(32'h20, 32'h77777777, 0, 1'b0);
        fetch_one(32'h24, 32'h88888888, 0, 1'b0);
        pc_valid_i = 1'b1;
        pc_i       = 32'h28;
        pc4_i      = 32'h2C;
        tick();
        pc_valid_i = 1'b0;
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        flush_i    = 1'b1;
        tick();
        flush_i = 1'b0;
        sb.delete();
        chk("flush_count", {{(32-CNTW){1'b0}}, count_o}, 32'd0);
        chk("flush_valid", {31'd0, id_valid_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEADBEEF;
        #1;
        chk("killed_nobypass", {31'd0, id_valid_o}, 32'd0);
        tick();
        imem_rvalid_i = 1'b0;
        chk("killed_count", {{(32-CNTW){1'b0}}, count_o}, 32'd0);
        chk("killed_valid", {31'd0, id_valid_o}, 32'd0);
        fetch_one(32'h100, 32'h00000013, 0, 1'b0);
        chk("post_flush_count", {{(32-CNTW){1'b0}}, count_o}, 32'd1);
        pop_check();

        // Flush in IDLE blocks acceptance.
        pc_valid_i = 1'b1;
        pc_i       = 32'h200;
        pc4_i      = 32'h204;
        flush_i    = 1'b1;
        #1;
        chk("idle_flush_ready", {31'd0, pc_ready_o}, 32'd0);
        tick();
        flush_i    = 1'b0;
        pc_valid_i = 1'b0;
        chk("idle_flush_noreq", {31'd0, imem_req_o}, 32'd0);

        // Reset while a request is outstanding and one entry is queued.
        fetch_one(32'h1F0, 32'hAAAAAAAA, 0, 1'b0);
        pc_valid_i = 1'b1;
        pc_i       = 32'h200;
        pc4_i      = 32'h204;
        tick();
        pc_valid_i = 1'b0;
        chk("rreq_req", {31'd0, imem_req_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rreq_req0", {31'd0, imem_req_o}, 32'd0);
        chk("rreq_valid0", {31'd0, id_valid_o}, 32'd0);
        chk("rreq_count0", {{(32-CNTW){1'b0}}, count_o}, 32'd0);
        chk("rreq_addr0", imem_addr_o, 32'd0);
        sb.delete();
        tick();
        #2;
        rst = 1'b0;
        tick();
        first_fetch();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
